ex_stage: RTL and testbench

//  Execute stage of the 5-stage LA32R pipeline; sits between decode and memory stages.

---
 rtl/la32r_pkg.sv | 49 ++++
 rtl/ex_alu.sv | 66 ++++++
 rtl/ex_stage.sv | 140 ++++++++++++++
 tb/tb_ex_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la32r_pkg.sv
// Shared LA32R execute-stage definitions: ALU op indices, widths and the EX->MS bus.
// Build option: EXE_MUL_EN widens alu_op to 15 bits for mul.w / mulh.w / mulh.wu.
package la32r_pkg;

`ifdef EXE_MUL_EN
  localparam int ALU_OP_W = 15;
`else
  localparam int ALU_OP_W = 12;
`endif

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_NOR   = 5;
  localparam int OP_OR    = 6;
  localparam int OP_XOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;
  localparam int OP_MUL   = 12;
  localparam int OP_MULH  = 13;
  localparam int OP_MULHU = 14;

  localparam logic [31:0] RST_PC = 32'h1bfffffc;

  typedef struct packed {
    logic [31:0] pc;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
  } es2ms_bus_t;

  typedef struct packed {
    logic [31:0]         pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic [31:0]         rkd_value;
    logic                res_from_mem;
    logic                gr_we;
    logic                mem_we;
    logic [4:0]          dest;
  } es_latch_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational LA32R ALU; one-hot alu_op selects the result, all-zero alu_op yields 0.
// With EXE_MUL_EN it also forms the 64-bit product and selects words of the registered product.
module ex_alu
  import la32r_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [31:0]         alu_src1,
  input  logic [31:0]         alu_src2,
`ifdef EXE_MUL_EN
  input  logic [63:0]         mul_prod,
  output logic [63:0]         mul_full,
`endif
  output logic [31:0]         alu_result
);

  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic        slt_res;
  logic        sltu_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;

  assign add_res  = alu_src1 + alu_src2;
  assign sub_res  = alu_src1 - alu_src2;
  assign slt_res  = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_res = alu_src1 < alu_src2;
  assign sll_res  = alu_src1 << alu_src2[4:0];
  assign srl_res  = alu_src1 >> alu_src2[4:0];
  assign sra_res  = $signed(alu_src1) >>> alu_src2[4:0];

`ifdef EXE_MUL_EN
  logic               mul_signed;
  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [65:0] mul_ext;

  // One 33x33 signed multiplier covers both signed and unsigned high words.
  assign mul_signed = alu_op[OP_MULH];
  assign mul_a      = {mul_signed & alu_src1[31], alu_src1};
  assign mul_b      = {mul_signed & alu_src2[31], alu_src2};
  assign mul_ext    = mul_a * mul_b;
  assign mul_full   = mul_ext[63:0];
`endif

  always_comb begin
    alu_result = ({32{alu_op[OP_ADD]}}  & add_res)
               | ({32{alu_op[OP_SUB]}}  & sub_res)
               | ({32{alu_op[OP_SLT]}}  & {31'b0, slt_res})
               | ({32{alu_op[OP_SLTU]}} & {31'b0, sltu_res})
               | ({32{alu_op[OP_AND]}}  & (alu_src1 & alu_src2))
               | ({32{alu_op[OP_NOR]}}  & ~(alu_src1 | alu_src2))
               | ({32{alu_op[OP_OR]}}   & (alu_src1 | alu_src2))
               | ({32{alu_op[OP_XOR]}}  & (alu_src1 ^ alu_src2))
               | ({32{alu_op[OP_SLL]}}  & sll_res)
               | ({32{alu_op[OP_SRL]}}  & srl_res)
               | ({32{alu_op[OP_SRA]}}  & sra_res)
               | ({32{alu_op[OP_LUI]}}  & alu_src2);
`ifdef EXE_MUL_EN
    alu_result = alu_result
               | ({32{alu_op[OP_MUL]}}                     & mul_prod[31:0])
               | ({32{alu_op[OP_MULH] | alu_op[OP_MULHU]}} & mul_prod[63:32]);
`endif
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage LA32R pipeline: operand latch, handshake, ALU and data-SRAM request.
// Build option: EXE_MUL_EN adds a two-cycle multiplier (mul.w, mulh.w, mulh.wu).
module ex_stage
  import la32r_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                ds2es_valid,
  output logic                es_allowin,
  input  logic [31:0]         ds_pc,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [31:0]         alu_src1,
  input  logic [31:0]         alu_src2,
  input  logic [31:0]         rkd_value,
  input  logic                res_from_mem,
  input  logic                gr_we,
  input  logic                mem_we,
  input  logic [4:0]          dest,
  input  logic                ms_allowin,
  output logic                es2ms_valid,
  output logic [31:0]         es_pc,
  output logic                es_res_from_mem,
  output logic                es_gr_we,
  output logic [4:0]          es_dest,
  output logic [31:0]         es_alu_result,
  output logic                es_valid,
  output logic                es_fwd_block,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata
);

  es_latch_t  lat_q, lat_d;
  logic       es_valid_q, es_valid_d;
  logic       es_ready_go;
  logic [31:0] alu_result;
  es2ms_bus_t es2ms_bus;

  // Fields only move when EX can take a new instruction; otherwise the held one is frozen.
  always_comb begin
    es_valid_d = es_valid_q;
    lat_d      = lat_q;
    if (es_allowin) begin
      es_valid_d = ds2es_valid;
      if (ds2es_valid) begin
        lat_d.pc           = ds_pc;
        lat_d.alu_op       = alu_op;
        lat_d.src1         = alu_src1;
        lat_d.src2         = alu_src2;
        lat_d.rkd_value    = rkd_value;
        lat_d.res_from_mem = res_from_mem;
        lat_d.gr_we        = gr_we;
        lat_d.mem_we       = mem_we;
        lat_d.dest         = dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      lat_q      <= '{pc: RST_PC, default: '0};
    end else begin
      es_valid_q <= es_valid_d;
      lat_q      <= lat_d;
    end
  end

`ifdef EXE_MUL_EN
  logic        is_mul;
  logic        mul_busy_q, mul_busy_d;
  logic [63:0] mul_prod_q, mul_prod_d;
  logic [63:0] mul_full;

  assign is_mul      = |lat_q.alu_op[OP_MULHU:OP_MUL];
  assign es_ready_go = ~(is_mul & ~mul_busy_q);

  // First mul cycle captures the product; busy drops as the instruction leaves EX.
  always_comb begin
    mul_busy_d = mul_busy_q;
    mul_prod_d = mul_prod_q;
    if (es_valid_q & is_mul & ~mul_busy_q) begin
      mul_busy_d = 1'b1;
      mul_prod_d = mul_full;
    end else if (es_valid_q & es_ready_go & ms_allowin) begin
      mul_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_busy_q <= 1'b0;
      mul_prod_q <= '0;
    end else begin
      mul_busy_q <= mul_busy_d;
      mul_prod_q <= mul_prod_d;
    end
  end

  ex_alu u_alu (
    .alu_op     (lat_q.alu_op),
    .alu_src1   (lat_q.src1),
    .alu_src2   (lat_q.src2),
    .mul_prod   (mul_prod_q),
    .mul_full   (mul_full),
    .alu_result (alu_result)
  );
`else
  assign es_ready_go = 1'b1;

  ex_alu u_alu (
    .alu_op     (lat_q.alu_op),
    .alu_src1   (lat_q.src1),
    .alu_src2   (lat_q.src2),
    .alu_result (alu_result)
  );
`endif

  assign es_allowin  = ~es_valid_q | (es_ready_go & ms_allowin);
  assign es2ms_valid = es_valid_q & es_ready_go;
  assign es_valid    = es_valid_q;

  assign es2ms_bus = '{pc: lat_q.pc, res_from_mem: lat_q.res_from_mem, gr_we: lat_q.gr_we,
                       dest: lat_q.dest, alu_result: alu_result};

  assign es_pc           = es2ms_bus.pc;
  assign es_res_from_mem = es2ms_bus.res_from_mem;
  assign es_gr_we        = es2ms_bus.gr_we;
  assign es_dest         = es2ms_bus.dest;
  assign es_alu_result   = es2ms_bus.alu_result;

  // Requests are re-issued every held cycle; the SRAM treats repeats as the same access.
  assign es_fwd_block    = es_valid_q & (lat_q.res_from_mem | ~es_ready_go);
  assign data_sram_en    = es_valid_q & (lat_q.res_from_mem | lat_q.mem_we);
  assign data_sram_we    = {4{es_valid_q & lat_q.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = lat_q.rkd_value;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed scenarios then randomized traffic against a reference model.
// Multiply scenarios are included when EXE_MUL_EN is defined.
module tb_ex_stage;
  import la32r_pkg::*;

  logic                clk;
  logic                reset;
  logic                ds2es_valid;
  logic                es_allowin;
  logic [31:0]         ds_pc;
  logic [ALU_OP_W-1:0] alu_op;
  logic [31:0]         alu_src1;
  logic [31:0]         alu_src2;
  logic [31:0]         rkd_value;
  logic                res_from_mem;
  logic                gr_we;
  logic                mem_we;
  logic [4:0]          dest;
  logic                ms_allowin;
  logic                es2ms_valid;
  logic [31:0]         es_pc;
  logic                es_res_from_mem;
  logic                es_gr_we;
  logic [4:0]          es_dest;
  logic [31:0]         es_alu_result;
  logic                es_valid;
  logic                es_fwd_block;
  logic                data_sram_en;
  logic [3:0]          data_sram_we;
  logic [31:0]         data_sram_addr;
  logic [31:0]         data_sram_wdata;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        rfm;
    logic        mwe;
    logic [31:0] wdata;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  bit   rand_phase = 0;

  ex_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds2es_valid     (ds2es_valid),
    .es_allowin      (es_allowin),
    .ds_pc           (ds_pc),
    .alu_op          (alu_op),
    .alu_src1        (alu_src1),
    .alu_src2        (alu_src2),
    .rkd_value       (rkd_value),
    .res_from_mem    (res_from_mem),
    .gr_we           (gr_we),
    .mem_we          (mem_we),
    .dest            (dest),
    .ms_allowin      (ms_allowin),
    .es2ms_valid     (es2ms_valid),
    .es_pc           (es_pc),
    .es_res_from_mem (es_res_from_mem),
    .es_gr_we        (es_gr_we),
    .es_dest         (es_dest),
    .es_alu_result   (es_alu_result),
    .es_valid        (es_valid),
    .es_fwd_block    (es_fwd_block),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference ALU from the instruction definitions; op < 0 means an all-zero alu_op.
  function automatic logic [31:0] refAlu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    sp = sa * sb;
    up = ua * ub;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (ua < ub) ? 32'd1 : 32'd0;
      OP_AND:  return a & b;
      OP_NOR:  return ~(a | b);
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'(sa >>> b[4:0]);
      OP_LUI:  return b;
`ifdef EXE_MUL_EN
      OP_MUL:   return up[31:0];
      OP_MULH:  return sp[63:32];
      OP_MULHU: return up[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Offers one instruction until EX accepts it, recording its expected result on acceptance.
  task automatic applyStimulus(input int op, input logic [31:0] s1, input logic [31:0] s2,
                               input logic [31:0] rkd, input logic rfm, input logic gwe,
                               input logic mwe, input logic [4:0] d, input logic [31:0] pc);
    exp_t e;
    ds2es_valid  = 1'b1;
    ds_pc        = pc;
    alu_op       = '0;
    if (op >= 0) alu_op[op] = 1'b1;
    alu_src1     = s1;
    alu_src2     = s2;
    rkd_value    = rkd;
    res_from_mem = rfm;
    gr_we        = gwe;
    mem_we       = mwe;
    dest         = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (es_allowin) begin
        e.pc = pc; e.result = refAlu(op, s1, s2); e.dest = d;
        e.gr_we = gwe; e.rfm = rfm; e.mwe = mwe; e.wdata = rkd;
        expq.push_back(e);
        @(posedge clk);
        #1;
        ds2es_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    failures++;
    checks++;
    $display("[TB] FAIL accept_timeout: got allowin=0 expected allowin=1 within 200 cycles");
    ds2es_valid = 1'b0;
  endtask

  // Monitor: every transfer to the memory stage is compared with the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && es2ms_valid && ms_allowin) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_output", 64'(es_pc), 64'hffffffff_ffffffff);
      end else begin
        e = expq.pop_front();
        checkOutput("pc", 64'(es_pc), 64'(e.pc));
        checkOutput("result", 64'(es_alu_result), 64'(e.result));
        checkOutput("dest", 64'(es_dest), 64'(e.dest));
        checkOutput("gr_we", 64'(es_gr_we), 64'(e.gr_we));
        checkOutput("res_from_mem", 64'(es_res_from_mem), 64'(e.rfm));
        checkOutput("sram_en", 64'(data_sram_en), 64'(e.rfm | e.mwe));
        checkOutput("sram_we", 64'(data_sram_we), e.mwe ? 64'hf : 64'h0);
        checkOutput("sram_addr", 64'(data_sram_addr), 64'(e.result));
        checkOutput("sram_wdata", 64'(data_sram_wdata), 64'(e.wdata));
        checkOutput("fwd_block", 64'(es_fwd_block), 64'(e.rfm));
      end
    end
  end

  initial begin
    int op;
    logic [31:0] s2;
    logic rfm;
    logic mwe;
    ds2es_valid = 0; ds_pc = 0; alu_op = '0; alu_src1 = 0; alu_src2 = 0; rkd_value = 0;
    res_from_mem = 0; gr_we = 0; mem_we = 0; dest = 0; ms_allowin = 1;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    checkOutput("rst_es_valid", 64'(es_valid), 64'd0);
    checkOutput("rst_es_pc", 64'(es_pc), 64'h1bfffffc);
    checkOutput("rst_sram_en", 64'(data_sram_en), 64'd0);
    checkOutput("rst_allowin", 64'(es_allowin), 64'd1);
    @(posedge clk);
    #1;

    applyStimulus(OP_ADD, 32'd5, 32'd7, 32'd0, 0, 1, 0, 5'd3, 32'h1c000000);
    @(negedge clk);
    checkOutput("add_es2ms_valid", 64'(es2ms_valid), 64'd1);
    checkOutput("add_result", 64'(es_alu_result), 64'd12);
    checkOutput("add_fwd_block", 64'(es_fwd_block), 64'd0);
    @(posedge clk);
    #1;

    applyStimulus(OP_ADD, 32'h1c000000, 32'd8, 32'hdeadbeef, 0, 0, 1, 5'd0, 32'h1c000004);
    @(negedge clk);
    checkOutput("st_addr", 64'(data_sram_addr), 64'h1c000008);
    checkOutput("st_we", 64'(data_sram_we), 64'hf);
    checkOutput("st_en", 64'(data_sram_en), 64'd1);
    @(posedge clk);
    #1;

    // Load held by memory stage while decode offers a different instruction.
    ms_allowin = 0;
    applyStimulus(OP_ADD, 32'h1c000100, 32'd4, 32'd0, 1, 1, 0, 5'd9, 32'h1c000008);
    ds2es_valid = 1; ds_pc = 32'h1c00000c; alu_src1 = 32'h11111111; dest = 5'd20; res_from_mem = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("held_allowin", 64'(es_allowin), 64'd0);
      checkOutput("held_pc", 64'(es_pc), 64'h1c000008);
      checkOutput("held_addr", 64'(data_sram_addr), 64'h1c000104);
      checkOutput("held_fwd_block", 64'(es_fwd_block), 64'd1);
      checkOutput("held_sram_en", 64'(data_sram_en), 64'd1);
      @(posedge clk);
      #1;
    end
    ms_allowin = 1;
    applyStimulus(OP_OR, 32'h11111111, 32'h0000f000, 32'd0, 0, 1, 0, 5'd20, 32'h1c00000c);

    applyStimulus(OP_SRA, 32'h80000000, 32'd4, 32'd0, 0, 1, 0, 5'd4, 32'h1c000010);
    @(negedge clk);
    checkOutput("sra_result", 64'(es_alu_result), 64'hf8000000);
    @(posedge clk);
    #1;
    applyStimulus(OP_SLTU, 32'd1, 32'hffffffff, 32'd0, 0, 1, 0, 5'd5, 32'h1c000014);
    @(negedge clk);
    checkOutput("sltu_result", 64'(es_alu_result), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(-1, 32'h12345678, 32'h9abcdef0, 32'd0, 0, 1, 0, 5'd6, 32'h1c000018);

`ifdef EXE_MUL_EN
    applyStimulus(OP_MULH, 32'hffffffff, 32'd2, 32'd0, 0, 1, 0, 5'd7, 32'h1c00001c);
    @(negedge clk);
    checkOutput("mul_stall_valid", 64'(es2ms_valid), 64'd0);
    checkOutput("mul_stall_fwd", 64'(es_fwd_block), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("mul_done_valid", 64'(es2ms_valid), 64'd1);
    checkOutput("mul_done_result", 64'(es_alu_result), 64'hffffffff);
    @(posedge clk);
    #1;

    // Reset lands while the multiply is busy; the instruction is abandoned.
    ms_allowin = 0;
    applyStimulus(OP_MULHU, 32'hffffffff, 32'hffffffff, 32'd0, 0, 1, 0, 5'd8, 32'h1c000020);
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    ms_allowin = 1;
    void'(expq.pop_back());
    @(negedge clk);
    checkOutput("mul_rst_valid", 64'(es_valid), 64'd0);
    checkOutput("mul_rst_es2ms", 64'(es2ms_valid), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(OP_MUL, 32'h00012345, 32'h00006789, 32'd0, 0, 1, 0, 5'd9, 32'h1c000024);
`endif

    // Randomized traffic with random memory-stage backpressure.
    rand_phase = 1;
    fork
      while (rand_phase) begin
        @(posedge clk);
        #1;
        ms_allowin = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int n = 0; n < 300; n++) begin
      op  = int'($urandom_range(0, ALU_OP_W));
      if (op == ALU_OP_W) op = -1;
      s2  = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 40));
      rfm = ($urandom_range(0, 4) == 0);
      mwe = !rfm && ($urandom_range(0, 4) == 0);
      applyStimulus(op, $urandom(), s2, $urandom(), rfm, !mwe, mwe,
                    5'($urandom_range(0, 31)), $urandom());
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_phase = 0;
    @(posedge clk);
    #1;
    ms_allowin = 1;
    for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_queue", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
